adc_multi_current_check: RTL and testbench
==========================================

// Module: adc_multi_current_check
// PURPOSE
//  Multi-channel successor to the single-channel ADC current check. Takes a time-multiplexed
//  ADC sample stream tagged with a channel index, and per channel runs (a) a debounced
//  instantaneous peak check and (b) a debounced block-average drive-current check.
//  Any trip latches a sticky fail, feeding the safety interlock until clear_fail is pulsed.
// PARAMETERS
//  NUM_CH      4   number of ADC channels monitored (1..16)
//  DATA_W      16  ADC sample width, unsigned
//  LIMIT_W     32  limit register width; samples zero-extended to LIMIT_W before compare
//  AVG_LOG2    3   average block length = 2**AVG_LOG2 samples per channel (0 = no averaging)
//  PEAK_TRIPS  2   consecutive over-peak samples on one channel required to trip (>=1)
//  DRIVE_TRIPS 4   consecutive over-limit block averages on one channel required to trip (>=1)
// PORTS
//  clk                       in   1                  system clock
//  rst                       in   1                  asynchronous reset, active-high
//  clear_fail                in   1                  sync pulse: clear sticky fails, counters, accumulators
//  adc_data_valid            in   1                  sample strobe, one sample per cycle max
//  adc_channel               in   $clog2(NUM_CH)|1   channel index of adc_data
//  adc_data                  in   DATA_W             unsigned sample
//  drive_current_limit       in   LIMIT_W            block-average limit (all channels)
//  power_peak_current_limit  in   LIMIT_W            instantaneous peak limit (all channels)
//  current_limit_fail        out  1                  OR of all sticky fails
//  peak_fail_ch              out  NUM_CH             sticky per-channel peak trip
//  drive_fail_ch             out  NUM_CH             sticky per-channel average trip
//  first_fail_ch             out  4                  channel of first trip since clear; valid when fail
//  bad_channel               out  1                  sticky: valid sample with adc_channel >= NUM_CH
// BEHAVIOUR
//  - Reset (async, rst=1): all outputs 0, all accumulators, sample counters, trip counters 0.
//  - Limits sampled every cycle, unsigned compare, strict greater-than (== limit passes).
//  - Per channel state: acc[DATA_W+AVG_LOG2], scnt[AVG_LOG2], pk_cnt, dr_cnt.
//  - On valid sample for channel c (c < NUM_CH):
//    * peak: data > power_peak_current_limit -> pk_cnt++ (saturating at PEAK_TRIPS);
//      else pk_cnt=0. When pk_cnt reaches PEAK_TRIPS, peak_fail_ch[c] <= 1.
//    * avg: sum = acc + data. If scnt == 2**AVG_LOG2-1: avg = sum >> AVG_LOG2 (truncating),
//      acc <= 0, scnt <= 0, and avg > drive_current_limit -> dr_cnt++ (saturating),
//      else dr_cnt=0; dr_cnt reaching DRIVE_TRIPS sets drive_fail_ch[c]. Otherwise acc<=sum, scnt++.
//    * samples of other channels never touch channel c state (interleaving allowed, any order).
//  - Latency: fail bits and current_limit_fail assert on the clock edge that registers the
//    tripping sample, i.e. visible the cycle after adc_data_valid. No pipeline beyond that.
//  - Top-level FSM: ARMED -> TRIPPED on first per-channel trip; first_fail_ch latched then
//    (simultaneous peak+drive on same sample: same channel; only one sample/cycle so no tie).
//    TRIPPED: further trips still set their sticky bits; first_fail_ch frozen.
//    TRIPPED -> ARMED only on clear_fail.
//  - clear_fail: zeroes sticky bits, first_fail_ch, bad_channel, all counters and accumulators
//    (partial blocks discarded). Sample on the same cycle as clear_fail is dropped; clear wins.
//  - adc_channel >= NUM_CH with valid: sample ignored, bad_channel <= 1 (not a current fail).
//  - Averaging: accumulator cannot overflow (width DATA_W+AVG_LOG2). AVG_LOG2=0: every sample is a block.
//  - Limit >= 2**DATA_W effectively disables that check.
//  - rst asserted mid-block: everything cleared asynchronously; no partial state survives.
// TESTING
//  1 Peak debounce: ch2, peak_limit=1000, samples 1001,999,1001,1001 -> fail only after 4th,
//    peak_fail_ch=4'b0100, first_fail_ch=2, current_limit_fail 1 cycle after 4th valid.
//  2 Boundary: sample == limit (1000) repeated 20x on ch0 -> no fail; 1001 twice -> fail.
//  3 Average: drive_limit=500, ch1 blocks of 8 {400x4,700x4}=550 avg x4 blocks -> drive_fail_ch[1]
//    after 32nd sample; block avg 500 interleaved resets dr_cnt, no trip.
//  4 Interleave: ch0..ch3 round-robin, only ch3 over limit -> only bit 3 set; others' acc unaffected.
//  5 clear_fail same cycle as tripping sample -> no fail; mid-block clear discards partial sum.
//  6 adc_channel=5 with NUM_CH=4 -> bad_channel=1, current_limit_fail stays 0; rst mid-run -> all 0.

Source files
------------

// File: rtl/adc_multi_current_check.sv
// Multi-channel ADC current supervisor: per-channel debounced peak and block-average
// checks on a channel-tagged sample stream, latched into a sticky safety fail.
//
// state   | meaning
// ARMED   | no trip since reset/clear; first trip latches first_fail_ch
// TRIPPED | at least one sticky fail set; first_fail_ch frozen until clear_fail
module adc_multi_current_check #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 16,
  parameter int LIMIT_W     = 32,
  parameter int AVG_LOG2    = 3,
  parameter int PEAK_TRIPS  = 2,
  parameter int DRIVE_TRIPS = 4,
  localparam int CH_W       = $clog2(NUM_CH) | 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_fail,
  input  logic               adc_data_valid,
  input  logic [CH_W-1:0]    adc_channel,
  input  logic [DATA_W-1:0]  adc_data,
  input  logic [LIMIT_W-1:0] drive_current_limit,
  input  logic [LIMIT_W-1:0] power_peak_current_limit,
  output logic               current_limit_fail,
  output logic [NUM_CH-1:0]  peak_fail_ch,
  output logic [NUM_CH-1:0]  drive_fail_ch,
  output logic [3:0]         first_fail_ch,
  output logic               bad_channel
);

  localparam int ACC_W    = DATA_W + AVG_LOG2;
  localparam int SC_W     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int CMP_W    = (LIMIT_W > ACC_W) ? LIMIT_W : ACC_W;
  localparam int PK_W     = $clog2(PEAK_TRIPS + 1);
  localparam int DR_W     = $clog2(DRIVE_TRIPS + 1);
  localparam int BLK_LAST = (1 << AVG_LOG2) - 1;

  typedef enum logic {ST_ARMED, ST_TRIPPED} state_t;

  state_t state, state_nxt;

  logic [ACC_W-1:0] acc  [NUM_CH];
  logic [SC_W-1:0]  scnt [NUM_CH];
  logic [PK_W-1:0]  pk_cnt [NUM_CH];
  logic [DR_W-1:0]  dr_cnt [NUM_CH];

  logic             ch_ok, smp;
  logic [ACC_W-1:0] sel_acc, sum, avg;
  logic [SC_W-1:0]  sel_scnt;
  logic [PK_W-1:0]  sel_pk, pk_nxt;
  logic [DR_W-1:0]  sel_dr, dr_nxt;
  logic             over_pk, over_dr, blk_end, pk_trip, dr_trip, trip;

  // Mux out the state of the addressed channel; out-of-range indices select nothing.
  always_comb begin
    sel_acc  = '0;
    sel_scnt = '0;
    sel_pk   = '0;
    sel_dr   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(adc_channel) == c) begin
        sel_acc  = acc[c];
        sel_scnt = scnt[c];
        sel_pk   = pk_cnt[c];
        sel_dr   = dr_cnt[c];
      end
    end
  end

  always_comb begin
    ch_ok   = int'(adc_channel) < NUM_CH;
    smp     = adc_data_valid && ch_ok && !clear_fail;
    over_pk = CMP_W'(adc_data) > CMP_W'(power_peak_current_limit);
    sum     = sel_acc + ACC_W'(adc_data);
    avg     = sum >> AVG_LOG2;
    blk_end = sel_scnt == SC_W'(BLK_LAST);
    over_dr = CMP_W'(avg) > CMP_W'(drive_current_limit);
    pk_nxt  = '0;
    if (over_pk)
      pk_nxt = (sel_pk == PK_W'(PEAK_TRIPS)) ? sel_pk : sel_pk + PK_W'(1);
    dr_nxt  = '0;
    if (over_dr)
      dr_nxt = (sel_dr == DR_W'(DRIVE_TRIPS)) ? sel_dr : sel_dr + DR_W'(1);
    pk_trip = smp && (pk_nxt == PK_W'(PEAK_TRIPS));
    dr_trip = smp && blk_end && (dr_nxt == DR_W'(DRIVE_TRIPS));
    trip    = pk_trip || dr_trip;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c]    <= '0;
        scnt[c]   <= '0;
        pk_cnt[c] <= '0;
        dr_cnt[c] <= '0;
      end
      peak_fail_ch  <= '0;
      drive_fail_ch <= '0;
      bad_channel   <= 1'b0;
    end else if (clear_fail) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c]    <= '0;
        scnt[c]   <= '0;
        pk_cnt[c] <= '0;
        dr_cnt[c] <= '0;
      end
      peak_fail_ch  <= '0;
      drive_fail_ch <= '0;
      bad_channel   <= 1'b0;
    end else if (adc_data_valid) begin
      if (!ch_ok) bad_channel <= 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_ok && int'(adc_channel) == c) begin
          pk_cnt[c] <= pk_nxt;
          if (pk_trip) peak_fail_ch[c] <= 1'b1;
          if (blk_end) begin
            acc[c]    <= '0;
            scnt[c]   <= '0;
            dr_cnt[c] <= dr_nxt;
            if (dr_trip) drive_fail_ch[c] <= 1'b1;
          end else begin
            acc[c]  <= sum;
            scnt[c] <= scnt[c] + SC_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_ARMED;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ARMED:   if (!clear_fail && trip) state_nxt = ST_TRIPPED;
      ST_TRIPPED: if (clear_fail) state_nxt = ST_ARMED;
      default:    state_nxt = ST_ARMED;
    endcase
  end

  always_comb begin
    current_limit_fail = (state == ST_TRIPPED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              first_fail_ch <= '0;
    else if (clear_fail)                  first_fail_ch <= '0;
    else if (state == ST_ARMED && trip)   first_fail_ch <= 4'(adc_channel);
  end

endmodule

// File: tb/tb_adc_multi_current_check.sv
// Bench for adc_multi_current_check: directed scenarios plus random traffic against
// a queue-based reference model.
module tb_adc_multi_current_check;
  localparam int NUM_CH = 4;
  localparam int PT     = 2;
  localparam int DT     = 4;
  localparam int BLK    = 8;

  logic        clk = 1'b0;
  logic        rst, clear_fail, adc_data_valid;
  logic [2:0]  adc_channel;
  logic [15:0] adc_data;
  logic [31:0] drive_current_limit, power_peak_current_limit;
  logic        current_limit_fail, bad_channel;
  logic [3:0]  peak_fail_ch, drive_fail_ch, first_fail_ch;

  adc_multi_current_check dut (
    .clk(clk), .rst(rst), .clear_fail(clear_fail), .adc_data_valid(adc_data_valid),
    .adc_channel(adc_channel), .adc_data(adc_data),
    .drive_current_limit(drive_current_limit),
    .power_peak_current_limit(power_peak_current_limit),
    .current_limit_fail(current_limit_fail), .peak_fail_ch(peak_fail_ch),
    .drive_fail_ch(drive_fail_ch), .first_fail_ch(first_fail_ch), .bad_channel(bad_channel)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned blkq [NUM_CH][$];
  int          pk_run [NUM_CH];
  int          dr_run [NUM_CH];
  logic [3:0]  m_pk, m_dr, m_first;
  logic        m_bad, m_trip;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      blkq[c].delete();
      pk_run[c] = 0;
      dr_run[c] = 0;
    end
    m_pk = '0; m_dr = '0; m_first = '0; m_bad = 1'b0; m_trip = 1'b0;
  endtask

  task automatic model_sample(input int ch, input longint unsigned data);
    longint unsigned sum;
    bit tripped;
    if (ch >= NUM_CH) begin
      m_bad = 1'b1;
      return;
    end
    tripped = 1'b0;
    if (data > longint'(power_peak_current_limit)) begin
      pk_run[ch] = (pk_run[ch] < PT) ? pk_run[ch] + 1 : PT;
      if (pk_run[ch] == PT) begin m_pk[ch] = 1'b1; tripped = 1'b1; end
    end else pk_run[ch] = 0;
    blkq[ch].push_back(int'(data));
    if (blkq[ch].size() == BLK) begin
      sum = 0;
      foreach (blkq[ch][i]) sum += blkq[ch][i];
      blkq[ch].delete();
      if (sum / BLK > longint'(drive_current_limit)) begin
        dr_run[ch] = (dr_run[ch] < DT) ? dr_run[ch] + 1 : DT;
        if (dr_run[ch] == DT) begin m_dr[ch] = 1'b1; tripped = 1'b1; end
      end else dr_run[ch] = 0;
    end
    if (tripped && !m_trip) begin
      m_trip  = 1'b1;
      m_first = 4'(ch);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_fail"},  32'(current_limit_fail), 32'(m_trip));
    chk({tag, "_pk"},    32'(peak_fail_ch),       32'(m_pk));
    chk({tag, "_dr"},    32'(drive_fail_ch),      32'(m_dr));
    chk({tag, "_first"}, 32'(first_fail_ch),      32'(m_first));
    chk({tag, "_bad"},   32'(bad_channel),        32'(m_bad));
  endtask

  task automatic step(input bit v, input int ch, input int data, input bit clr, input string tag);
    @(negedge clk);
    adc_data_valid = v;
    adc_channel    = 3'(ch);
    adc_data       = 16'(data);
    clear_fail     = clr;
    @(posedge clk);
    #1;
    if (clr)    model_clear();
    else if (v) model_sample(ch, longint'(data));
    check_outputs(tag);
    adc_data_valid = 1'b0;
    clear_fail     = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_clear();
    check_outputs(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear_fail = 1'b0; adc_data_valid = 1'b0; adc_channel = '0; adc_data = '0;
    drive_current_limit = 32'hFFFF_FFFF; power_peak_current_limit = 32'hFFFF_FFFF;
    model_clear();
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // peak debounce on ch2
    power_peak_current_limit = 1000;
    step(1, 2, 1001, 0, "t1a");
    step(1, 2, 999,  0, "t1b");
    step(1, 2, 1001, 0, "t1c");
    chk("t1_nofail_yet", 32'(current_limit_fail), 0);
    step(1, 2, 1001, 0, "t1d");
    chk("t1_pk_ch", 32'(peak_fail_ch), 32'b0100);
    chk("t1_first", 32'(first_fail_ch), 2);
    step(0, 0, 0, 1, "t1clr");

    // equal-to-limit passes
    for (int i = 0; i < 20; i++) step(1, 0, 1000, 0, "t2eq");
    chk("t2_eq_nofail", 32'(current_limit_fail), 0);
    step(1, 0, 1001, 0, "t2a");
    step(1, 0, 1001, 0, "t2b");
    chk("t2_trip", 32'(peak_fail_ch), 32'b0001);
    step(0, 0, 0, 1, "t2clr");

    // block average on ch1, then an at-limit block breaks the streak
    power_peak_current_limit = 32'hFFFF_FFFF;
    drive_current_limit = 500;
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < BLK; i++) step(1, 1, (i < 4) ? 400 : 700, 0, "t3a");
    for (int i = 0; i < BLK; i++) step(1, 1, 500, 0, "t3eq");
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < BLK; i++) step(1, 1, (i < 4) ? 400 : 700, 0, "t3b");
    chk("t3_no_trip", 32'(drive_fail_ch), 0);
    for (int i = 0; i < BLK; i++) step(1, 1, (i < 4) ? 400 : 700, 0, "t3c");
    chk("t3_trip", 32'(drive_fail_ch), 32'b0010);
    chk("t3_first", 32'(first_fail_ch), 1);
    step(0, 0, 0, 1, "t3clr");

    // round-robin, only ch3 over the average limit
    for (int i = 0; i < 4 * BLK * DT; i++)
      step(1, i % 4, (i % 4 == 3) ? 900 : 300, 0, "t4");
    chk("t4_only_ch3", 32'(drive_fail_ch), 32'b1000);
    step(0, 0, 0, 1, "t4clr");

    // clear wins over a tripping sample; mid-block clear realigns blocks
    power_peak_current_limit = 1000;
    step(1, 0, 1001, 0, "t5a");
    step(1, 0, 1001, 1, "t5b");
    chk("t5_clear_wins", 32'(current_limit_fail), 0);
    power_peak_current_limit = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) step(1, 1, 10000, 0, "t5p");
    step(0, 0, 0, 1, "t5clr");
    for (int i = 0; i < BLK * DT - 1; i++) step(1, 1, 600, 0, "t5q");
    chk("t5_partial_dropped", 32'(drive_fail_ch), 0);
    step(1, 1, 600, 0, "t5r");
    chk("t5_trip", 32'(drive_fail_ch), 32'b0010);
    step(0, 0, 0, 1, "t5clr2");

    // out-of-range channel, then reset mid-block
    step(1, 5, 60000, 0, "t6a");
    chk("t6_bad", 32'(bad_channel), 1);
    chk("t6_no_fail", 32'(current_limit_fail), 0);
    power_peak_current_limit = 100;
    step(1, 3, 200, 0, "t6b");
    step(1, 3, 200, 0, "t6c");
    step(1, 2, 50, 0, "t6d");
    do_reset("t6rst");

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      int r, ch;
      bit clr;
      if (i % 150 == 0) begin
        power_peak_current_limit = ($urandom_range(0, 9) == 0) ? 32'h0001_0000 : $urandom_range(20000, 60000);
        drive_current_limit      = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom_range(15000, 45000);
      end
      r   = $urandom_range(0, 99);
      clr = (r < 2);
      ch  = ($urandom_range(0, 29) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      step(r < 85, ch, $urandom_range(0, 65535), clr, "rnd");
      if (i == 777) do_reset("rnd_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
